sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It is generalised in data width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a defined read-and-write-when-full behaviour. It sits between any two same-clock producer/consumer blocks as the standard elastic buffer.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 16, number of entries; power of two, ≥ 2
- AF_THRESH, 12, almost_full asserts when count ≥ AF_THRESH; 1..DEPTH
- AE_THRESH, 4, almost_empty asserts when count ≤ AE_THRESH; 0..DEPTH-1
- CW (localparam) = $clog2(DEPTH)+1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- w_en  in  1  write request
- r_en  in  1  read request
- data_in  in  DATA_WIDTH  write data, sampled when a write is accepted
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write requested and rejected
- underflow  out  1  one-cycle pulse: read requested and rejected

## Operation
- Storage: DEPTH × DATA_WIDTH array. wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally. count is a separate CW-bit register.
- Read accepted (rd_ok) = r_en && count != 0.
- Write accepted (wr_ok) = w_en && (count != DEPTH || rd_ok).
  - A write while full is accepted only when a read is accepted in the same cycle.
- On rd_ok: rd_ptr += 1. On wr_ok: mem[wr_ptr] ← data_in and wr_ptr += 1.
- count update:
  - +1 if wr_ok && !rd_ok
  - −1 if rd_ok && !wr_ok
  - unchanged otherwise
- Simultaneous read and write on empty: the write is accepted, the read is rejected, underflow pulses, and count becomes 1.
- Simultaneous read and write on full: both are accepted, count stays DEPTH, full stays high, and the new word lands in the slot just vacated.
- overflow is registered as w_en && !wr_ok. underflow is registered as r_en && !rd_ok.
- Rejected operations leave the pointers, count and memory unchanged.
- full, empty, almost_full and almost_empty are decoded only from the count register. There is no combinational path from any input to any flag.
- Reset, also when asserted mid-operation:
  - wr_ptr = rd_ptr = 0, count = 0
  - data_out = 0, overflow = underflow = 0
  - hence empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - Memory contents are not cleared.
  - Requests in the reset cycle are ignored.

## Timing
- Default mode (registered read):
  - data_out ← mem[rd_ptr] on the edge where rd_ok. Data is valid one cycle after r_en is sampled.
  - data_out holds its value when there is no accepted read.
- Write-to-read latency: a word written at edge N can be read at edge N+1 and appears on data_out after edge N+1.
- Flags, count and error pulses update on the same edge as the pointer change that causes them. overflow and underflow are high for exactly one cycle per rejected request.
- Back-to-back reads and writes are sustainable every cycle; the throughput is 1 word/cycle.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out continuously presents mem[rd_ptr] whenever count != 0, with no read latency.
  - r_en consumes the presented word, and the next word is visible after that edge.
  - A word written into an empty FIFO at edge N is on data_out, with empty = 0, after edge N.
  - data_out is undefined and not checked while empty.
  - Reset still forces the flags and count as above.
- Undefined: registered-read behaviour as in Timing.
- All accept/reject rules, flags and error pulses are identical in both modes.

## Test plan
- Reset then fill: rst high for 3 cycles, then 16 consecutive writes of 0x01..0x10.
  - count steps 1..16.
  - almost_empty falls when count = 5.
  - almost_full rises when count = 12.
  - full = 1 after the 16th write.
- Overflow/drain: with the FIFO full, write 0xAA with r_en = 0.
  - overflow pulses for 1 cycle, count stays 16, 0xAA is dropped.
  - Then 16 reads return 0x01..0x10 in order, empty = 1 afterwards.
  - A 17th read pulses underflow and leaves data_out at 0x10.
- Full pass-through: with the FIFO full of 0x01..0x10, assert w_en = r_en = 1 with data_in = 0x55.
  - Read returns 0x01, count stays 16, no overflow.
  - The 16th subsequent read returns 0x55.
- Empty simultaneous: with the FIFO empty, assert w_en = r_en = 1 with data_in = 0x3C.
  - underflow pulses, count = 1.
  - The next read returns 0x3C.
- Wrap-around with random traffic: 500 cycles of random w_en/r_en and random data against a scoreboard queue.
  - Zero mismatches.
  - count always equals the queue size.
  - Pointers wrap at least 10 times.
- Reset mid-operation: with count = 7, pulse rst for 1 cycle.
  - Next cycle: count = 0, empty = 1, data_out = 0.
  - A subsequent write/read of 0x77 returns 0x77.
  - With SYNC_FIFO_FWFT_EN, 0x77 appears on data_out the cycle after it is written.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO used as the standard elastic buffer between
// same-clock producer/consumer blocks. Provides an occupancy count,
// programmable almost-full / almost-empty thresholds, one-cycle
// overflow / underflow error pulses and a defined read-and-write-when-full
// behaviour (both accepted, the new word lands in the slot just vacated).
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : registered read, data_out valid one cycle after an accepted
//               read and held otherwise.
//   defined   : first-word fall-through, data_out presents the head word
//               whenever the FIFO is not empty; r_en consumes it.
//
// Parameters:
//   DATA_WIDTH  width of each stored word
//   DEPTH       number of entries (power of two, >= 2)
//   AF_THRESH   almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH   almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous reset, active-high
//   w_en          write request
//   r_en          read request
//   data_in       write data, sampled when a write is accepted
//   data_out      read data
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy, 0..DEPTH
//   overflow      one-cycle pulse: write requested and rejected
//   underflow     one-cycle pulse: read requested and rejected
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  rd_ok;
  logic                  wr_ok;

  // A write while full is still accepted when a read frees a slot in the
  // same cycle; a read on empty is always rejected, even alongside a write.
  assign rd_ok = r_en && (count_q != '0);
  assign wr_ok = w_en && ((count_q != DEPTH_C) || rd_ok);

  // Storage is deliberately not reset; the write is gated during reset so
  // requests in the reset cycle leave the array untouched.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap modulo DEPTH through natural overflow of AW bits; the
  // separate count register disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow  <= w_en && !wr_ok;
      underflow <= r_en && !rd_ok;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly from the array; zero while empty keeps
  // the output deterministic even though it is not meaningful then.
  assign data_out = (count_q != '0) ? mem[rd_ptr] : '0;
`else
  logic [DATA_WIDTH-1:0] data_q;

  // Registered read: on a simultaneous read/write when full, rd_ptr equals
  // wr_ptr, and the non-blocking semantics return the old word while the
  // new word overwrites the vacated slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_ok) begin
      data_q <= mem[rd_ptr];
    end
  end

  assign data_out = data_q;
`endif

  // Flags decode only the count register, so no input reaches them
  // combinationally.
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

endmodule
